cb_porta_rd_seq: RTL and testbench

//  Read sequencer for covariance-buffer (CB) BRAM port A, directly upstream of the CB port-A lane mapper.

---
 rtl/cb_porta_rd_seq.sv | 134 +++++++++++++
 tb/tb_cb_porta_rd_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cb_porta_rd_seq.sv
// Covariance-buffer port-A read sequencer.
// Issues one burst of row reads and aligns mapper select/valid to BRAM data.
module cb_porta_rd_seq #(
  parameter int L       = 4,
  parameter int RSA_DW  = 16,
  parameter int ROW_LEN = 10,
  parameter int CB_AW   = 10,
  parameter int RD_LAT  = 1,
  localparam int LEN_W  = $clog2(ROW_LEN + 1)
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_tgt,
  input  logic [1:0]       cmd_dir,
  input  logic             cmd_l_k_0,
  input  logic [CB_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             CB_ena,
  output logic [CB_AW-1:0] CB_addra,
  output logic [3:0]       CB_douta_sel,
  output logic             l_k_0,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
);

  localparam int DW = $clog2(RD_LAT + 2);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(ROW_LEN);
  localparam logic [DW-1:0]    DRN_INIT = DW'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       tgt_q;
  logic [1:0]       dir_q;
  logic [LEN_W-1:0] rem;
  logic [DW-1:0]    drn;
  logic [LEN_W-1:0] eff_len;
  logic             accept;

  logic [RD_LAT-1:0] pv;
  logic [3:0]        ps [RD_LAT];

  // Ready is forced low while reset is held so nothing is accepted.
  assign cmd_ready = (state == S_IDLE) && !sys_rst;
  assign accept    = cmd_valid && cmd_ready;
  assign eff_len   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign CB_douta_sel = ps[RD_LAT-1];

  // Burst FSM: latch the command, walk addresses, then drain the read pipe.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      CB_ena   <= 1'b0;
      CB_addra <= '0;
      tgt_q    <= '0;
      dir_q    <= '0;
      l_k_0    <= 1'b0;
      rem      <= '0;
      drn      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            tgt_q <= cmd_tgt;
            dir_q <= cmd_dir;
            l_k_0 <= cmd_l_k_0;
            if (eff_len == '0 || cmd_tgt == 2'b00) begin
              state <= S_DONE;
            end else begin
              state    <= S_ISSUE;
              CB_ena   <= 1'b1;
              CB_addra <= cmd_addr;
              rem      <= eff_len;
            end
          end
        end
        S_ISSUE: begin
          if (rem > LEN_W'(1)) begin
            rem      <= rem - LEN_W'(1);
            CB_addra <= CB_addra + CB_AW'(1);
          end else begin
            state  <= S_DRAIN;
            CB_ena <= 1'b0;
            drn    <= DRN_INIT;
          end
        end
        S_DRAIN: begin
          if (drn == '0) begin
            state <= S_DONE;
          end else begin
            drn <= drn - DW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Select/valid shift register tracking the BRAM read latency.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      pv       <= '0;
      dout_vld <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        ps[i] <= 4'b0000;
      end
    end else begin
      pv[0]    <= CB_ena;
      ps[0]    <= CB_ena ? {tgt_q, dir_q} : 4'b0000;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
      end
      dout_vld <= pv[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_cb_porta_rd_seq.sv
// Directed bench for the CB port-A read sequencer.
// Vector table plus hand sequences for held-valid and mid-burst reset.
module tb_cb_porta_rd_seq;

  localparam int ROW_LEN = 10;
  localparam int CB_AW   = 10;
  localparam int RD_LAT  = 1;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             sys_rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_tgt;
  logic [1:0]       cmd_dir;
  logic             cmd_l_k_0;
  logic [CB_AW-1:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             CB_ena;
  logic [CB_AW-1:0] CB_addra;
  logic [3:0]       CB_douta_sel;
  logic             l_k_0;
  logic             dout_vld;
  logic             busy;
  logic             done;

  cb_porta_rd_seq #(
    .L(4), .RSA_DW(16), .ROW_LEN(ROW_LEN),
    .CB_AW(CB_AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tgt(cmd_tgt), .cmd_dir(cmd_dir),
    .cmd_l_k_0(cmd_l_k_0), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .CB_ena(CB_ena),
    .CB_addra(CB_addra), .CB_douta_sel(CB_douta_sel),
    .l_k_0(l_k_0), .dout_vld(dout_vld),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       tgt;
    logic [1:0]       dir;
    logic             lk;
    logic [CB_AW-1:0] addr;
    logic [LEN_W-1:0] len;
    int               n;
    logic [3:0]       sel;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_tgt   = v.tgt;
    cmd_dir   = v.dir;
    cmd_l_k_0 = v.lk;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Expected outputs c cycles after the accept edge of a burst.
  task automatic check_cycle(input string tag, input int c, input vec_t v);
    int               dn;
    logic             e_ena, e_vld, e_done, e_busy;
    logic [3:0]       e_sel;
    logic [CB_AW-1:0] e_addr;
    dn     = (v.n == 0) ? 1 : v.n + 3;
    e_ena  = (c >= 1 && c <= v.n);
    e_addr = v.addr + CB_AW'(c - 1);
    e_sel  = (c >= 2 && c <= v.n + 1) ? v.sel : 4'b0000;
    e_vld  = (c >= 3 && c <= v.n + 2);
    e_done = (c == dn);
    e_busy = (c >= 1 && c <= dn);
    chk({tag, "_ena"}, {31'd0, CB_ena}, {31'd0, e_ena});
    if (e_ena) chk({tag, "_addr"}, {22'd0, CB_addra}, {22'd0, e_addr});
    chk({tag, "_sel"}, {28'd0, CB_douta_sel}, {28'd0, e_sel});
    chk({tag, "_vld"}, {31'd0, dout_vld}, {31'd0, e_vld});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, "_rdy"}, {31'd0, cmd_ready}, {31'd0, !e_busy});
    if (e_busy && v.n > 0) chk({tag, "_lk"}, {31'd0, l_k_0}, {31'd0, v.lk});
  endtask

  vec_t vt [7];
  vec_t va, vb, vr;

  initial begin
    vt[0] = '{tgt:2'b01, dir:2'b01, lk:1'b0, addr:10'd5,    len:4'd3,  n:3,  sel:4'b0101};
    vt[1] = '{tgt:2'b11, dir:2'b11, lk:1'b1, addr:10'd100,  len:4'd2,  n:2,  sel:4'b1111};
    vt[2] = '{tgt:2'b10, dir:2'b10, lk:1'b0, addr:10'd1022, len:4'd4,  n:4,  sel:4'b1010};
    vt[3] = '{tgt:2'b01, dir:2'b01, lk:1'b0, addr:10'd40,   len:4'd0,  n:0,  sel:4'b0000};
    vt[4] = '{tgt:2'b10, dir:2'b01, lk:1'b1, addr:10'd7,    len:4'd15, n:10, sel:4'b1001};
    vt[5] = '{tgt:2'b00, dir:2'b01, lk:1'b0, addr:10'd9,    len:4'd5,  n:0,  sel:4'b0000};
    vt[6] = '{tgt:2'b01, dir:2'b00, lk:1'b0, addr:10'd300,  len:4'd1,  n:1,  sel:4'b0100};

    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    drive(vt[0]);
    #1;
    chk("rst_ena", {31'd0, CB_ena}, 32'd0);
    chk("rst_sel", {28'd0, CB_douta_sel}, 32'd0);
    chk("rst_vld", {31'd0, dout_vld}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_lk", {31'd0, l_k_0}, 32'd0);
    chk("rst_addr", {22'd0, CB_addra}, 32'd0);
    chk("rst_rdy", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    #1;
    chk("rel_rdy", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      int dn;
      wait_ready();
      drive(vt[i]);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      drive(vt[(i + 3) % 7]);
      dn = (vt[i].n == 0) ? 1 : vt[i].n + 3;
      for (int c = 1; c <= dn + 1; c++) begin
        check_cycle($sformatf("v%0d_c%0d", i, c), c, vt[i]);
        @(posedge clk);
        #1;
      end
    end

    // Held cmd_valid: second command taken only after done, with new fields.
    va = '{tgt:2'b01, dir:2'b01, lk:1'b0, addr:10'd10,  len:4'd2, n:2, sel:4'b0101};
    vb = '{tgt:2'b10, dir:2'b10, lk:1'b1, addr:10'd200, len:4'd1, n:1, sel:4'b1010};
    wait_ready();
    drive(va);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(vb);
    for (int c = 1; c <= 6; c++) begin
      check_cycle($sformatf("hA_c%0d", c), c, va);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check_cycle($sformatf("hB_c%0d", c), c, vb);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a burst.
    vr = '{tgt:2'b01, dir:2'b01, lk:1'b1, addr:10'd50, len:4'd8, n:8, sel:4'b0101};
    wait_ready();
    drive(vr);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_cycle($sformatf("r_c%0d", c), c, vr);
      if (c < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    sys_rst = 1'b1;
    #1;
    chk("mid_ena", {31'd0, CB_ena}, 32'd0);
    chk("mid_sel", {28'd0, CB_douta_sel}, 32'd0);
    chk("mid_vld", {31'd0, dout_vld}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_rdy", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    #1;
    chk("mid_rel_rdy", {31'd0, cmd_ready}, 32'd1);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_done_%0d", c), {31'd0, done}, 32'd0);
      chk($sformatf("post_ena_%0d", c), {31'd0, CB_ena}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
